// File: rtl/riscv_alu_issue_if.sv
// Handshake bundle for the ALU issue stage: instruction input channel,
// flush, and the registered operand channel toward riscv_alu.
interface riscv_alu_issue_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [3:0]      alu_op_o;
    logic [XLEN-1:0] alu_a_o;
    logic [XLEN-1:0] alu_b_o;
    logic [4:0]      rd_o;
    logic            illegal_o;

    modport slave (
        input  flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_op_o, alu_a_o, alu_b_o, rd_o, illegal_o
    );

    modport master (
        output flush_i, in_valid_i, instr_i, rs1_data_i, rs2_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_op_o, alu_a_o, alu_b_o, rd_o, illegal_o
    );
endinterface

// File: rtl/riscv_alu_issue.sv
// ALU issue stage: decodes RV32IM OP/OP-IMM into riscv_alu op/operands and
// presents them through an output register backed by a one-entry skid buffer.
module riscv_alu_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    riscv_alu_issue_if.slave  bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0010;
    localparam logic [3:0] OP_SRA  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            illegal;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_sext;
    logic [XLEN-1:0] shamt;
    logic            legal;
    entry_t          dec;
    logic            unused_rs1_idx;

    assign opcode         = bus.instr_i[6:0];
    assign funct3         = bus.instr_i[14:12];
    assign funct7         = bus.instr_i[31:25];
    assign imm_sext       = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};
    assign shamt          = {{(XLEN-5){1'b0}}, bus.instr_i[24:20]};
    assign unused_rs1_idx = ^bus.instr_i[19:15];

    always_comb begin
        dec    = '0;
        dec.rd = bus.instr_i[11:7];
        legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                dec.a = bus.rs1_data_i;
                dec.b = bus.rs2_data_i;
                case ({funct7, funct3})
                    10'b0000000_000: dec.op = OP_ADD;
                    10'b0000000_001: dec.op = OP_SLL;
                    10'b0000000_010: dec.op = OP_SLT;
                    10'b0000000_011: dec.op = OP_SLTU;
                    10'b0000000_100: dec.op = OP_XOR;
                    10'b0000000_101: dec.op = OP_SRL;
                    10'b0000000_110: dec.op = OP_OR;
                    10'b0000000_111: dec.op = OP_AND;
                    10'b0100000_000: dec.op = OP_SUB;
                    10'b0100000_101: dec.op = OP_SRA;
                    10'b0000001_000: dec.op = OP_MUL;
                    default:         legal  = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec.a = bus.rs1_data_i;
                dec.b = imm_sext;
                case (funct3)
                    3'b000: dec.op = OP_ADD;
                    3'b010: dec.op = OP_SLT;
                    3'b011: dec.op = OP_SLTU;
                    3'b100: dec.op = OP_XOR;
                    3'b110: dec.op = OP_OR;
                    3'b111: dec.op = OP_AND;
                    3'b001: begin
                        dec.b = shamt;
                        if (funct7 == 7'b0000000) dec.op = OP_SLL;
                        else                      legal  = 1'b0;
                    end
                    default: begin
                        dec.b = shamt;
                        if (funct7 == 7'b0000000)      dec.op = OP_SRL;
                        else if (funct7 == 7'b0100000) dec.op = OP_SRA;
                        else                           legal  = 1'b0;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Illegal entries still flow downstream, but with a neutral payload.
        if (!legal) begin
            dec.op      = '0;
            dec.a       = '0;
            dec.b       = '0;
            dec.illegal = 1'b1;
        end
    end

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;
    logic   xfer;

    assign accept = bus.in_valid_i && !skid_valid_q;
    assign xfer   = out_valid_q && bus.out_ready_i;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (bus.flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (xfer || !out_valid_q) begin
            // Skid is older than anything arriving now; in_ready is low while it is held.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.in_ready_o  = !skid_valid_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.alu_op_o    = out_q.op;
    assign bus.alu_a_o     = out_q.a;
    assign bus.alu_b_o     = out_q.b;
    assign bus.rd_o        = out_q.rd;
    assign bus.illegal_o   = out_q.illegal;
endmodule

// File: tb/tb_riscv_alu_issue.sv
// Directed-vector bench for riscv_alu_issue: decode cases, backpressure,
// flush and asynchronous reset, all against hand-computed expectations.
module tb_riscv_alu_issue;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    riscv_alu_issue_if #(.XLEN(32)) bus ();

    riscv_alu_issue #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        bus.in_valid_i = 1'b1;
        bus.instr_i    = instr;
        bus.rs1_data_i = rs1;
        bus.rs2_data_i = rs2;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        drive(instr, rs1, rs2);
        step();
        bus.in_valid_i = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic ill);
        check({tag, ".valid"}, {31'b0, bus.out_valid_o}, 32'd1);
        check({tag, ".op"},    {28'b0, bus.alu_op_o},    {28'b0, op});
        check({tag, ".a"},     bus.alu_a_o,              a);
        check({tag, ".b"},     bus.alu_b_o,              b);
        check({tag, ".rd"},    {27'b0, bus.rd_o},        {27'b0, rd});
        check({tag, ".ill"},   {31'b0, bus.illegal_o},   {31'b0, ill});
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".valid"}, {31'b0, bus.out_valid_o}, 32'd0);
        check({tag, ".ready"}, {31'b0, bus.in_ready_o},  32'd1);
        check({tag, ".op"},    {28'b0, bus.alu_op_o},    32'd0);
        check({tag, ".a"},     bus.alu_a_o,              32'd0);
        check({tag, ".b"},     bus.alu_b_o,              32'd0);
        check({tag, ".rd"},    {27'b0, bus.rd_o},        32'd0);
        check({tag, ".ill"},   {31'b0, bus.illegal_o},   32'd0);
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        bus.flush_i     = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.instr_i     = '0;
        bus.rs1_data_i  = '0;
        bus.rs2_data_i  = '0;
        bus.out_ready_i = 1'b1;
        #12;
        expect_reset("reset");
        rst_n = 1'b1;
        step();

        // Decode vectors, out_ready held high
        send(32'h00500093, 32'h12345678, 32'h0);
        expect_out("addi", 4'b0000, 32'h12345678, 32'h00000005, 5'd1, 1'b0);
        send(32'h40208033, 32'h0000001E, 32'h0000000A);
        expect_out("sub", 4'b0110, 32'h0000001E, 32'h0000000A, 5'd0, 1'b0);
        send(32'hFF000093, 32'h00000100, 32'h0);
        expect_out("addi_neg", 4'b0000, 32'h00000100, 32'hFFFFFFF0, 5'd1, 1'b0);
        send(32'h4020D193, 32'hFFFFFFF0, 32'h0);
        expect_out("srai", 4'b0011, 32'hFFFFFFF0, 32'h00000002, 5'd3, 1'b0);
        send(32'h6020D193, 32'hFFFFFFF0, 32'h55);
        expect_out("bad_shift", 4'b0000, 32'h0, 32'h0, 5'd3, 1'b1);
        send(32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D);
        expect_out("bad_opc", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b1);
        send(32'h02208033, 32'h00000007, 32'h00000006);
        expect_out("mul", 4'b1100, 32'h00000007, 32'h00000006, 5'd0, 1'b0);
        send(32'hFFF0B093, 32'h00000003, 32'h0);
        expect_out("sltiu", 4'b1010, 32'h00000003, 32'hFFFFFFFF, 5'd1, 1'b0);
        send(32'h0020E0B3, 32'h000000F0, 32'h0000000F);
        expect_out("or", 4'b1000, 32'h000000F0, 32'h0000000F, 5'd1, 1'b0);
        step();
        check("drain.valid", {31'b0, bus.out_valid_o}, 32'd0);

        // Backpressure: three back-to-back offers with out_ready low
        bus.out_ready_i = 1'b0;
        drive(32'h00100293, 32'h0, 32'h0);
        step();
        check("bp1.ready", {31'b0, bus.in_ready_o}, 32'd1);
        expect_out("bp1", 4'b0000, 32'h0, 32'h1, 5'd5, 1'b0);
        drive(32'h00200313, 32'h0, 32'h0);
        step();
        check("bp2.ready", {31'b0, bus.in_ready_o}, 32'd0);
        expect_out("bp2.hold", 4'b0000, 32'h0, 32'h1, 5'd5, 1'b0);
        drive(32'h00300393, 32'h0, 32'h0);
        step();
        check("bp3.ready", {31'b0, bus.in_ready_o}, 32'd0);
        expect_out("bp3.hold", 4'b0000, 32'h0, 32'h1, 5'd5, 1'b0);
        bus.out_ready_i = 1'b1;
        step();
        check("bp_rel.ready", {31'b0, bus.in_ready_o}, 32'd1);
        expect_out("bp_out2", 4'b0000, 32'h0, 32'h2, 5'd6, 1'b0);
        step();
        bus.in_valid_i = 1'b0;
        expect_out("bp_out3", 4'b0000, 32'h0, 32'h3, 5'd7, 1'b0);
        step();
        check("bp_end.valid", {31'b0, bus.out_valid_o}, 32'd0);

        // Flush with both entries occupied
        bus.out_ready_i = 1'b0;
        send(32'h00100293, 32'h0, 32'h0);
        send(32'h00200313, 32'h0, 32'h0);
        check("fl_full.ready", {31'b0, bus.in_ready_o}, 32'd0);
        bus.flush_i = 1'b1;
        drive(32'h00300393, 32'h0, 32'h0);
        step();
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        check("fl.valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("fl.ready", {31'b0, bus.in_ready_o},  32'd1);
        bus.out_ready_i = 1'b1;
        step();
        check("fl_after.valid", {31'b0, bus.out_valid_o}, 32'd0);

        // Flush coinciding with an accept into an empty stage discards it
        bus.flush_i = 1'b1;
        send(32'h00500093, 32'h1, 32'h0);
        bus.flush_i = 1'b0;
        check("fl_acc.valid", {31'b0, bus.out_valid_o}, 32'd0);

        // Asynchronous reset mid-stream, away from any clock edge
        bus.out_ready_i = 1'b0;
        send(32'h00500093, 32'h12345678, 32'h0);
        send(32'h00200313, 32'h0, 32'h0);
        expect_out("pre_rst", 4'b0000, 32'h12345678, 32'h5, 5'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_reset("async_rst");
        #3;
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        step();
        check("post_rst.valid", {31'b0, bus.out_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
